dram_responder: RTL

//  Memory-side responder for the core's fetch port and its load/store (LSU) data port.
//  - Accepts one request at a time through a req/gnt handshake and returns data after a

---
 rtl/dram_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dram_responder.sv
// dram_responder: single-outstanding memory responder shared by the fetch port
// and the LSU data port. Word-addressed 32-bit storage with byte-lane writes.
// Responses arrive a fixed LATENCY cycles after the grant as a one-cycle rvalid pulse.
// The data port wins over fetch because it belongs to the older instruction.
// LATENCY must stay within 1..15 so that it fits the 4-bit latency counter.
module dram_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        instr_gnt_op,
  output logic        instr_rvalid_op,
  output logic [31:0] instr_rdata_op,
  output logic        instr_err_op,
  input  logic        data_req_ip,
  input  logic        data_we_ip,
  input  logic [3:0]  data_be_ip,
  input  logic [31:0] data_addr_ip,
  input  logic [31:0] data_wdata_ip,
  output logic        data_gnt_op,
  output logic        data_rvalid_op,
  output logic [31:0] data_rdata_op,
  output logic        data_err_op
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   cnt_q;
  logic         port_q;
  logic         err_q;
  logic [31:0]  rdata_q;

  logic [31:0]  mem [DEPTH_WORDS];

  logic         grant_data;
  logic         grant_instr;
  logic         grant_any;
  logic [31:0]  sel_addr;
  logic [29:0]  word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic         range_err;
  logic         port_err;
  logic         req_err;
  logic         do_store;
  logic         do_load;
  logic         resp_valid;

  // State register; reset drops any in-flight response by returning to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant arbitration (IDLE only, data before fetch) and next-state selection.
  // Grants are also held low while reset is asserted so every output reads 0.
  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_instr = 1'b0;
    case (state_q)
      IDLE: begin
        grant_data  = reset & mem_en & data_req_ip;
        grant_instr = reset & mem_en & instr_req_ip & ~data_req_ip;
        if (grant_data | grant_instr) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode the granted request: address, error classification and access type.
  always_comb begin
    grant_any = grant_data | grant_instr;
    sel_addr  = grant_data ? data_addr_ip : instr_addr_ip;
    word_idx  = sel_addr[31:2];
    mem_idx   = word_idx[IDX_W-1:0];
    range_err = (word_idx >= 30'(DEPTH_WORDS));
    port_err  = grant_data ? (data_be_ip == 4'b0000) : (sel_addr[1:0] != 2'b00);
    req_err   = range_err | port_err;
    do_store  = grant_data & data_we_ip & ~req_err;
    do_load   = grant_any & ~(grant_data & data_we_ip) & ~req_err;
  end

  // Capture the response at the grant edge and run the latency countdown in WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else if (grant_any) begin
      cnt_q   <= 4'(LATENCY - 1);
      port_q  <= grant_data;
      err_q   <= req_err;
      rdata_q <= do_load ? mem[mem_idx] : 32'h0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Storage array, deliberately not reset; stores commit lane by lane at the grant edge.
  always_ff @(posedge clock) begin
    if (do_store) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (data_be_ip[lane]) begin
          mem[mem_idx][lane*8 +: 8] <= data_wdata_ip[lane*8 +: 8];
        end
      end
    end
  end

  // Steer the response to the captured port; data and error read 0 outside rvalid.
  always_comb begin
    resp_valid      = (state_q == RESP);
    instr_gnt_op    = grant_instr;
    data_gnt_op     = grant_data;
    instr_rvalid_op = resp_valid & ~port_q;
    data_rvalid_op  = resp_valid & port_q;
    instr_rdata_op  = instr_rvalid_op ? rdata_q : 32'h0;
    data_rdata_op   = data_rvalid_op ? rdata_q : 32'h0;
    instr_err_op    = instr_rvalid_op & err_q;
    data_err_op     = data_rvalid_op & err_q;
  end

endmodule
